conv_mac_sequencer: RTL and testbench
=====================================

Name: conv_mac_sequencer

Overview:
- Controller that sequences the convolution multiply-accumulate datapath (multiplier, adder and accumulator register) to compute Z[n] = sum over k of X[k]*Y[n-k].
- Walks every output index n = 0 .. sizeX+sizeY-2.
- Drives read addresses to the X and Y sample memories and the enable/clear controls of the accumulator, then commits each finished sum to the Z memory.
- Sits between the top-level start/done handshake and the datapath plus memories.

Parameters:
- ADDR_WIDTH_X, 5, X memory address width; max sizeX = 2**ADDR_WIDTH_X.
- ADDR_WIDTH_Y, 5, Y memory address width; max sizeY = 2**ADDR_WIDTH_Y.
- ADDR_WIDTH_Z, 6, Z memory address width; must satisfy 2**ADDR_WIDTH_Z >= maxX+maxY-1.

Ports:
- clk  in  1  system clock, rising edge.
- rsth  in  1  synchronous active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- sizeX_i  in  ADDR_WIDTH_X+1  X length, 0..2**ADDR_WIDTH_X.
- sizeY_i  in  ADDR_WIDTH_Y+1  Y length, 0..2**ADDR_WIDTH_Y.
- memX_addr_o  out  ADDR_WIDTH_X  X read address.
- memX_rd_o  out  1  X read strobe.
- memY_addr_o  out  ADDR_WIDTH_Y  Y read address.
- memY_rd_o  out  1  Y read strobe.
- macEn_o  out  1  accumulator enable (en_i of the MAC block).
- macClr_o  out  1  accumulator clear (clr_i of the MAC block).
- memZ_addr_o  out  ADDR_WIDTH_Z  Z write address.
- memZ_we_o  out  1  Z write enable; data comes directly from the MAC output.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: clk and rsth are the only clock and reset.
  - rsth is synchronous and active-high.
  - On rsth, the FSM goes to IDLE and every output is 0.
  - Reset mid-operation aborts immediately; no further Z writes occur.
- Memory timing: X and Y memories have synchronous read with 1-cycle latency.
- Start: in IDLE, start_i=1 latches sizeX_i and sizeY_i, sets n=0 and enters CLR.
  - start_i is ignored in all other states.
  - If either size is 0, the FSM goes IDLE -> DONE with no memory accesses and no Z writes.
- Per-output bounds:
  - kmin = max(0, n-(sizeY-1)); kmax = min(n, sizeX-1); L = kmax-kmin+1, always >= 1.
- FSM states: IDLE, CLR, MAC, DRAIN, WRITE, DONE.
  - CLR (1 cycle): macClr_o=1, k=kmin.
  - MAC (L cycles): each cycle issues memX_addr_o=k, memY_addr_o=n-k with both rd strobes high, then k++. Leaves after the cycle with k=kmax.
  - macEn_o is the read strobe registered by one cycle, so it is high in the last L-1 MAC cycles and in DRAIN. This gives exactly L accumulates.
  - DRAIN (1 cycle): final accumulate; no reads.
  - WRITE (1 cycle): memZ_we_o=1, memZ_addr_o=n. If n == sizeX+sizeY-2, go to DONE; otherwise n++ and go to CLR.
  - DONE (1 cycle): done_o=1, busy_o=0, then IDLE.
- busy_o: 1 in CLR, MAC, DRAIN and WRITE.
- Latency: cycles from the start edge to the done_o cycle = sum over n of (L_n+3) + 1.
- Arithmetic: index arithmetic uses ADDR_WIDTH_Z+1 bits to avoid wrap. Address outputs are truncations of in-range values only.
- Idle outputs: address outputs hold 0 whenever their strobe is low.
- Overflow: the accumulator width is owned by the datapath; the sequencer performs no overflow checks.

Optional Feature:
- Macro: CONV_MAC_SEQUENCER_PERF_CNT_EN.
- When defined:
  - Adds output cycleCnt_o (32 bits).
  - Cleared on accepted start; increments every busy cycle.
  - Holds its value after DONE until the next start; reset value 0.
- When not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_mac_sequencer_pkg holds:
  - the state enum typedef (IDLE..DONE);
  - localparam helpers for index width (ADDR_WIDTH_Z+1).
- Sub-module conv_bounds_calc (combinational): takes n, sizeX and sizeY; returns kmin and kmax. Reused by the verification model.

Test Plan:
- sizeX=1, sizeY=1, start pulse:
  - CLR at cycle 1, MAC at 2 (addr 0/0), DRAIN at 3 with macEn_o=1, WRITE at 4 (addrZ=0), done_o at 5.
  - Exactly 1 enable and 1 write.
- sizeX=3, sizeY=3 with X=Y={1,2,3} against the real MAC block:
  - Z={1,4,10,12,9}; 5 writes; 9 macEn_o pulses; done_o 25 cycles after the start edge.
- sizeX=4, sizeY=2: per-n Y address sequence checked against conv_bounds_calc; Z address 4 written last, then done_o.
- sizeX=0, sizeY=5: done_o the cycle after start; no rd, we or en strobes; busy_o never high.
- Reset robustness:
  - rsth asserted during MAC of n=2 (sizes 3/3): all outputs 0 the next cycle, no further writes.
  - A new start with 2/2 then completes with Z={x0y0, x0y1+x1y0, x1y1}.
- start_i held high throughout the operation: exactly one operation runs.
  - With CONV_MAC_SEQUENCER_PERF_CNT_EN defined, cycleCnt_o equals the busy_o high-cycle count.

Source files
------------

// File: rtl/conv_mac_sequencer_pkg.sv
// Shared types and helpers for the convolution MAC sequencer.
package conv_mac_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StMac,
    StDrain,
    StWrite,
    StDone
  } seq_state_e;

  localparam int unsigned DefaultAddrWidthZ = 6;

  // Index arithmetic carries one bit beyond the Z address so n, k and n-k never wrap.
  function automatic int unsigned idx_width(input int unsigned addr_width_z);
    return addr_width_z + 1;
  endfunction

endpackage

// File: rtl/conv_bounds_calc.sv
// Combinational k range for one convolution output index n.
// kmin = max(0, n-(size_y-1)), kmax = min(n, size_x-1); sizes assumed non-zero.
module conv_bounds_calc #(
  parameter int unsigned IdxW = 7
) (
  input  logic [IdxW-1:0] n_i,
  input  logic [IdxW-1:0] size_x_i,
  input  logic [IdxW-1:0] size_y_i,
  output logic [IdxW-1:0] kmin_o,
  output logic [IdxW-1:0] kmax_o
);

  logic [IdxW-1:0] x_span;
  logic [IdxW-1:0] y_span;

  // Clamp n against both sequence lengths.
  always_comb begin
    x_span = size_x_i - IdxW'(1);
    y_span = size_y_i - IdxW'(1);
    kmin_o = (n_i > y_span) ? (n_i - y_span) : '0;
    kmax_o = (n_i < x_span) ? n_i : x_span;
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequencer for the convolution MAC datapath: Z[n] = sum_k X[k]*Y[n-k].
// Optional cycle counter output enabled by CONV_MAC_SEQUENCER_PERF_CNT_EN.
module conv_mac_sequencer
  import conv_mac_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_X = 5,
  parameter int unsigned ADDR_WIDTH_Y = 5,
  parameter int unsigned ADDR_WIDTH_Z = DefaultAddrWidthZ
) (
  input  logic                    clk,
  input  logic                    rsth,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH_X:0]   sizeX_i,
  input  logic [ADDR_WIDTH_Y:0]   sizeY_i,
  output logic [ADDR_WIDTH_X-1:0] memX_addr_o,
  output logic                    memX_rd_o,
  output logic [ADDR_WIDTH_Y-1:0] memY_addr_o,
  output logic                    memY_rd_o,
  output logic                    macEn_o,
  output logic                    macClr_o,
  output logic [ADDR_WIDTH_Z-1:0] memZ_addr_o,
  output logic                    memZ_we_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef CONV_MAC_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0]             cycleCnt_o
`endif
);

  localparam int unsigned IdxW = idx_width(ADDR_WIDTH_Z);

  seq_state_e      state_q;
  logic [IdxW-1:0] n_q;
  logic [IdxW-1:0] k_q;
  logic [IdxW-1:0] size_x_q;
  logic [IdxW-1:0] size_y_q;

  logic [IdxW-1:0] kmin;
  logic [IdxW-1:0] kmax;
  logic [IdxW-1:0] y_first;
  logic [IdxW-1:0] k_next;
  logic [IdxW-1:0] y_next;
  logic [IdxW-1:0] n_last;
  logic            size_zero;

  conv_bounds_calc #(
    .IdxW(IdxW)
  ) u_bounds (
    .n_i     (n_q),
    .size_x_i(size_x_q),
    .size_y_i(size_y_q),
    .kmin_o  (kmin),
    .kmax_o  (kmax)
  );

  // Address arithmetic for the first and subsequent MAC reads of the current n.
  always_comb begin
    y_first   = n_q - kmin;
    k_next    = k_q + IdxW'(1);
    y_next    = n_q - k_next;
    n_last    = size_x_q + size_y_q - IdxW'(2);
    size_zero = (sizeX_i == '0) || (sizeY_i == '0);
  end

  // Main FSM; every output is registered and reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rsth) begin
      state_q     <= StIdle;
      n_q         <= '0;
      k_q         <= '0;
      size_x_q    <= '0;
      size_y_q    <= '0;
      memX_addr_o <= '0;
      memX_rd_o   <= 1'b0;
      memY_addr_o <= '0;
      memY_rd_o   <= 1'b0;
      macEn_o     <= 1'b0;
      macClr_o    <= 1'b0;
      memZ_addr_o <= '0;
      memZ_we_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      memX_addr_o <= '0;
      memX_rd_o   <= 1'b0;
      memY_addr_o <= '0;
      memY_rd_o   <= 1'b0;
      // Read data arrives one cycle after the strobe, so enable trails it by one.
      macEn_o     <= memX_rd_o;
      macClr_o    <= 1'b0;
      memZ_addr_o <= '0;
      memZ_we_o   <= 1'b0;
      done_o      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            size_x_q <= IdxW'(sizeX_i);
            size_y_q <= IdxW'(sizeY_i);
            n_q      <= '0;
            if (size_zero) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end else begin
              state_q  <= StClr;
              macClr_o <= 1'b1;
              busy_o   <= 1'b1;
            end
          end
        end
        StClr: begin
          k_q         <= kmin;
          memX_rd_o   <= 1'b1;
          memY_rd_o   <= 1'b1;
          memX_addr_o <= ADDR_WIDTH_X'(kmin);
          memY_addr_o <= ADDR_WIDTH_Y'(y_first);
          state_q     <= StMac;
        end
        StMac: begin
          if (k_q == kmax) begin
            state_q <= StDrain;
          end else begin
            k_q         <= k_next;
            memX_rd_o   <= 1'b1;
            memY_rd_o   <= 1'b1;
            memX_addr_o <= ADDR_WIDTH_X'(k_next);
            memY_addr_o <= ADDR_WIDTH_Y'(y_next);
          end
        end
        StDrain: begin
          state_q     <= StWrite;
          memZ_we_o   <= 1'b1;
          memZ_addr_o <= ADDR_WIDTH_Z'(n_q);
        end
        StWrite: begin
          if (n_q == n_last) begin
            state_q <= StDone;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            n_q      <= n_q + IdxW'(1);
            state_q  <= StClr;
            macClr_o <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_MAC_SEQUENCER_PERF_CNT_EN
  // Busy-cycle counter: cleared on an accepted start, held after completion.
  always_ff @(posedge clk) begin
    if (rsth) begin
      cycleCnt_o <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      cycleCnt_o <= '0;
    end else if (busy_o) begin
      cycleCnt_o <= cycleCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer with behavioural memories and MAC.
module tb_conv_mac_sequencer;

  logic       clk = 1'b0;
  logic       rsth;
  logic       start_i;
  logic [5:0] sizeX_i;
  logic [5:0] sizeY_i;
  logic [4:0] memX_addr_o;
  logic       memX_rd_o;
  logic [4:0] memY_addr_o;
  logic       memY_rd_o;
  logic       macEn_o;
  logic       macClr_o;
  logic [5:0] memZ_addr_o;
  logic       memZ_we_o;
  logic       busy_o;
  logic       done_o;
`ifdef CONV_MAC_SEQUENCER_PERF_CNT_EN
  logic [31:0] cycleCnt_o;
`endif

  conv_mac_sequencer #(
    .ADDR_WIDTH_X(5),
    .ADDR_WIDTH_Y(5),
    .ADDR_WIDTH_Z(6)
  ) dut (
    .clk        (clk),
    .rsth       (rsth),
    .start_i    (start_i),
    .sizeX_i    (sizeX_i),
    .sizeY_i    (sizeY_i),
    .memX_addr_o(memX_addr_o),
    .memX_rd_o  (memX_rd_o),
    .memY_addr_o(memY_addr_o),
    .memY_rd_o  (memY_rd_o),
    .macEn_o    (macEn_o),
    .macClr_o   (macClr_o),
    .memZ_addr_o(memZ_addr_o),
    .memZ_we_o  (memZ_we_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef CONV_MAC_SEQUENCER_PERF_CNT_EN
    ,
    .cycleCnt_o (cycleCnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Sample memories (1-cycle synchronous read) and accumulator datapath.
  logic [7:0]  xmem [32];
  logic [7:0]  ymem [32];
  logic [7:0]  x_dout;
  logic [7:0]  y_dout;
  logic [31:0] acc;

  always @(posedge clk) begin
    if (memX_rd_o) x_dout <= xmem[memX_addr_o];
    if (memY_rd_o) y_dout <= ymem[memY_addr_o];
    if (rsth || macClr_o) acc <= 32'd0;
    else if (macEn_o) acc <= acc + 32'(x_dout) * 32'(y_dout);
  end

  int errors = 0;
  int checks = 0;

  logic [9:0]  addr_q [$];
  int          zaddr_q [$];
  logic [31:0] zdata_q [$];
  logic [31:0] zcap [64];
  logic        trace_clr [64];
  logic        trace_en [64];
  logic        trace_we [64];
  int          last_done_cyc;

  task automatic build_expect(input int sx, input int sy, output int lat, output int n_en,
                              output int n_we);
    addr_q.delete();
    zaddr_q.delete();
    zdata_q.delete();
    lat  = 1;
    n_en = 0;
    n_we = 0;
    if (sx == 0 || sy == 0) return;
    for (int n = 0; n <= sx + sy - 2; n++) begin
      int          len;
      logic [31:0] sum;
      len = 0;
      sum = 32'd0;
      for (int k = 0; k < sx; k++) begin
        int j;
        j = n - k;
        if (j >= 0 && j < sy) begin
          addr_q.push_back({5'(k), 5'(j)});
          sum = sum + 32'(xmem[k]) * 32'(ymem[j]);
          len++;
        end
      end
      zaddr_q.push_back(n);
      zdata_q.push_back(sum);
      lat  += len + 3;
      n_en += len;
      n_we += 1;
    end
  endtask

  task automatic run_op(input int sx, input int sy, input bit hold, input int abort_writes);
    int lat, exp_en, exp_we;
    int en_cnt, we_cnt, clr_cnt, busy_cnt;
    bit seen_done, aborted;
    logic [9:0] a;
    build_expect(sx, sy, lat, exp_en, exp_we);
    en_cnt = 0; we_cnt = 0; clr_cnt = 0; busy_cnt = 0;
    seen_done = 1'b0; aborted = 1'b0; last_done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      trace_clr[i] = 1'b0; trace_en[i] = 1'b0; trace_we[i] = 1'b0;
    end
    @(negedge clk);
    sizeX_i = 6'(sx);
    sizeY_i = 6'(sy);
    start_i = 1'b1;
    for (int c = 1; c <= lat + 6; c++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (c < 64) begin
        trace_clr[c] = macClr_o; trace_en[c] = macEn_o; trace_we[c] = memZ_we_o;
      end
      if (aborted || seen_done) begin
        checks++;
        if (memZ_we_o || memX_rd_o || memY_rd_o || done_o || busy_o || macClr_o) begin
          errors++;
          $display("FAIL quiet_after_end: cyc %0d we=%0b rd=%0b done=%0b busy=%0b, all 0 required",
                   c, memZ_we_o, memX_rd_o, done_o, busy_o);
        end
        continue;
      end
      en_cnt   += int'(macEn_o);
      clr_cnt  += int'(macClr_o);
      busy_cnt += int'(busy_o);
      checks++;
      if (memX_rd_o) begin
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_read: cyc %0d x=%0d y=%0d, no read expected", c, memX_addr_o,
                   memY_addr_o);
        end else begin
          a = addr_q.pop_front();
          if ({memX_addr_o, memY_addr_o} !== a || memY_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL read_addr: cyc %0d x=%0d y=%0d rdy=%0b, required x=%0d y=%0d", c,
                     memX_addr_o, memY_addr_o, memY_rd_o, a[9:5], a[4:0]);
          end
        end
      end else if (memY_rd_o || memX_addr_o !== 5'd0 || memY_addr_o !== 5'd0) begin
        errors++;
        $display("FAIL idle_addr: cyc %0d rdy=%0b x=%0d y=%0d, all 0 required", c, memY_rd_o,
                 memX_addr_o, memY_addr_o);
      end
      if (memZ_we_o) begin
        we_cnt++;
        checks++;
        if (zaddr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write: cyc %0d addr=%0d, no write expected", c, memZ_addr_o);
        end else begin
          int          ea;
          logic [31:0] ed;
          ea = zaddr_q.pop_front();
          ed = zdata_q.pop_front();
          if (int'(memZ_addr_o) != ea || acc !== ed) begin
            errors++;
            $display("FAIL z_write: addr=%0d data=%0d, required addr=%0d data=%0d", memZ_addr_o,
                     acc, ea, ed);
          end
          zcap[memZ_addr_o] = acc;
        end
      end
      if (abort_writes >= 0 && we_cnt == abort_writes && memX_rd_o) begin
        rsth = 1'b1;
        @(negedge clk);
        rsth = 1'b0;
        checks++;
        if (memX_rd_o || memY_rd_o || memX_addr_o != 0 || memY_addr_o != 0 || macEn_o ||
            macClr_o || memZ_we_o || memZ_addr_o != 0 || busy_o || done_o) begin
          errors++;
          $display("FAIL abort_outputs: rd=%0b en=%0b we=%0b busy=%0b, all 0 required", memX_rd_o,
                   macEn_o, memZ_we_o, busy_o);
        end
        aborted = 1'b1;
        continue;
      end
      if (done_o) begin
        seen_done = 1'b1;
        last_done_cyc = c;
        if (hold) start_i = 1'b0;
        checks++;
        if (c != lat || busy_o) begin
          errors++;
          $display("FAIL done_latency: cyc %0d busy=%0b, required cyc %0d busy=0", c, busy_o, lat);
        end
        checks++;
        if (en_cnt != exp_en || we_cnt != exp_we || clr_cnt != exp_we) begin
          errors++;
          $display("FAIL strobe_counts: en=%0d we=%0d clr=%0d, required en=%0d we=%0d clr=%0d",
                   en_cnt, we_cnt, clr_cnt, exp_en, exp_we, exp_we);
        end
        checks++;
        if ((sx == 0 || sy == 0) && busy_cnt != 0) begin
          errors++;
          $display("FAIL zero_busy: busy cycles=%0d, required 0", busy_cnt);
        end
`ifdef CONV_MAC_SEQUENCER_PERF_CNT_EN
        checks++;
        if (cycleCnt_o != 32'(busy_cnt)) begin
          errors++;
          $display("FAIL cycle_cnt: got %0d, required %0d", cycleCnt_o, busy_cnt);
        end
`endif
      end
    end
    start_i = 1'b0;
    if (!aborted) begin
      checks++;
      if (!seen_done || addr_q.size() != 0 || zaddr_q.size() != 0) begin
        errors++;
        $display("FAIL completion: done_seen=%0b reads_left=%0d writes_left=%0d, required 1/0/0",
                 seen_done, addr_q.size(), zaddr_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rsth = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (memX_rd_o || memY_rd_o || memX_addr_o != 0 || memY_addr_o != 0 || macEn_o ||
        macClr_o || memZ_we_o || memZ_addr_o != 0 || busy_o || done_o) begin
      errors++;
      $display("FAIL reset_outputs: rd=%0b en=%0b clr=%0b we=%0b busy=%0b done=%0b, all 0 required",
               memX_rd_o, macEn_o, macClr_o, memZ_we_o, busy_o, done_o);
    end
    rsth = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    xmem[0] = 8'd7;
    ymem[0] = 8'd6;
    run_op(1, 1, 1'b0, -1);
    checks++;
    if (trace_clr[1] !== 1'b1 || trace_en[2] !== 1'b0 || trace_en[3] !== 1'b1 ||
        trace_we[4] !== 1'b1 || last_done_cyc != 5) begin
      errors++;
      $display("FAIL single_timing: clr1=%0b en2=%0b en3=%0b we4=%0b done=%0d, required 1/0/1/1/5",
               trace_clr[1], trace_en[2], trace_en[3], trace_we[4], last_done_cyc);
    end
  endtask

  task automatic test_conv3();
    int exp_z [5];
    exp_z = '{1, 4, 10, 12, 9};
    for (int i = 0; i < 3; i++) begin
      xmem[i] = 8'(i + 1);
      ymem[i] = 8'(i + 1);
    end
    run_op(3, 3, 1'b0, -1);
    checks++;
    if (last_done_cyc != 25) begin
      errors++;
      $display("FAIL conv3_latency: done at %0d, required 25", last_done_cyc);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (zcap[i] !== 32'(exp_z[i])) begin
        errors++;
        $display("FAIL conv3_z%0d: got %0d, required %0d", i, zcap[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_rect();
    for (int i = 0; i < 4; i++) xmem[i] = 8'(3 * i + 2);
    ymem[0] = 8'd5;
    ymem[1] = 8'd9;
    run_op(4, 2, 1'b0, -1);
  endtask

  task automatic test_zero_size();
    run_op(0, 5, 1'b0, -1);
    checks++;
    if (last_done_cyc != 1) begin
      errors++;
      $display("FAIL zero_done: done at %0d, required 1", last_done_cyc);
    end
  endtask

  task automatic test_abort_restart();
    for (int i = 0; i < 3; i++) begin
      xmem[i] = 8'(i + 1);
      ymem[i] = 8'(i + 1);
    end
    run_op(3, 3, 1'b0, 2);
    xmem[0] = 8'd2; xmem[1] = 8'd3;
    ymem[0] = 8'd5; ymem[1] = 8'd7;
    for (int i = 0; i < 64; i++) zcap[i] = 32'd0;
    run_op(2, 2, 1'b0, -1);
    checks++;
    if (zcap[0] !== 32'd10 || zcap[1] !== 32'd29 || zcap[2] !== 32'd21) begin
      errors++;
      $display("FAIL restart_z: got %0d,%0d,%0d, required 10,29,21", zcap[0], zcap[1], zcap[2]);
    end
  endtask

  task automatic test_hold_start();
    for (int i = 0; i < 5; i++) begin
      xmem[i] = 8'(i + 4);
      ymem[i] = 8'(11 - i);
    end
    run_op(2, 5, 1'b1, -1);
  endtask

  initial begin
    rsth    = 1'b1;
    start_i = 1'b0;
    sizeX_i = 6'd0;
    sizeY_i = 6'd0;
    for (int i = 0; i < 32; i++) begin
      xmem[i] = 8'd0;
      ymem[i] = 8'd0;
    end
    for (int i = 0; i < 64; i++) zcap[i] = 32'd0;
    test_reset();
    test_single();
    test_conv3();
    test_rect();
    test_zero_size();
    test_abort_restart();
    test_hold_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
